// File: rtl/muldiv_sequencer_if.sv
// Execute-stage request/response bundle for the iterative multiply/divide unit.
// Signals keep the pipeline-facing names used by the decoder and hazard logic.
interface muldiv_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    // start is sampled only while the unit is idle and flush is low; the
    // upstream stage holds its registers while stall is high, and result is
    // valid in the single cycle done is high (stall is already low then).
    logic                  start;
    logic [2:0]            funct3;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  flush;
    logic                  busy;
    logic                  stall;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;

    modport master (
        output start, funct3, op_a, op_b, flush,
        input  busy, stall, done, result
    );

    modport slave (
        input  start, funct3, op_a, op_b, flush,
        output busy, stall, done, result
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// RV32M iterative multiply/divide: one shift-add or restoring-subtract step per cycle.
// Define MULDIV_ZERO_SKIP_EN to finish zero-operand cases in PREP instead of iterating.
module muldiv_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    muldiv_sequencer_if.slave   bus,
    output logic [2:0]          dbg_state_o
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [2:0]      f3_q, f3_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [2*W-1:0]  prod_q, prod_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_q, neg_d;
    logic [W-1:0]    result_q, result_d;

    logic            is_div, sign_a, sign_b, res_neg, zero_skip;
    logic [W-1:0]    a_abs, b_abs, mul_sel, div_sel, fix_val;
    logic [W:0]      mul_sum, div_shift, div_trial;
    logic [2*W-1:0]  prod_neg, mul_src;

    // Signedness per funct3: MUL/MULH/MULHSU treat op_a as signed, MUL/MULH op_b too.
    assign is_div  = f3_q[2];
    assign sign_a  = a_q[W-1] & (is_div ? ~f3_q[0] : (f3_q[1:0] != 2'b11));
    assign sign_b  = b_q[W-1] & (is_div ? ~f3_q[0] : ~f3_q[1]);
    assign a_abs   = sign_a ? -a_q : a_q;
    assign b_abs   = sign_b ? -b_q : b_q;
    assign res_neg = (is_div ? f3_q[1] : (f3_q[1:0] == 2'b10)) ? sign_a : (sign_a ^ sign_b);

`ifdef MULDIV_ZERO_SKIP_EN
    assign zero_skip = is_div ? ((a_q == '0) && (b_q != '0)) : ((a_q == '0) || (b_q == '0));
`else
    assign zero_skip = 1'b0;
`endif

    // prod_q holds {acc, multiplier} for multiply and {remainder, quotient} for divide.
    assign mul_sum   = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, a_q} : '0);
    assign div_shift = prod_q[2*W-1:W-1];
    assign div_trial = div_shift - {1'b0, b_q};

    // The multiply sign fix must negate the full double-width product before selecting a half.
    assign prod_neg = -prod_q;
    assign mul_src  = neg_q ? prod_neg : prod_q;
    assign mul_sel  = (f3_q[1:0] == 2'b00) ? mul_src[W-1:0] : mul_src[2*W-1:W];
    assign div_sel  = f3_q[1] ? prod_q[2*W-1:W] : prod_q[W-1:0];
    assign fix_val  = is_div ? (neg_q ? -div_sel : div_sel) : mul_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            f3_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            f3_q     <= f3_d;
            a_q      <= a_d;
            b_q      <= b_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        f3_d     = f3_q;
        a_d      = a_q;
        b_d      = b_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        result_d = result_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    f3_d    = bus.funct3;
                    a_d     = bus.op_a;
                    b_d     = bus.op_b;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else if (is_div && (b_q == '0)) begin
                    result_d = f3_q[1] ? a_q : '1;
                    state_d  = S_DONE;
                end else if (is_div && !f3_q[0] && (a_q == MIN_NEG) && (b_q == '1)) begin
                    result_d = f3_q[1] ? '0 : MIN_NEG;
                    state_d  = S_DONE;
                end else if (zero_skip) begin
                    result_d = '0;
                    state_d  = S_DONE;
                end else begin
                    a_d     = a_abs;
                    b_d     = b_abs;
                    neg_d   = res_neg;
                    prod_d  = is_div ? {{W{1'b0}}, a_abs} : {{W{1'b0}}, b_abs};
                    cnt_d   = CW'(W - 1);
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (!is_div)
                        prod_d = {mul_sum, prod_q[W-1:1]};
                    else if (!div_trial[W])
                        prod_d = {div_trial[W-1:0], prod_q[W-2:0], 1'b1};
                    else
                        prod_d = {div_shift[W-1:0], prod_q[W-2:0], 1'b0};
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0)
                        state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = fix_val;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.stall   = (bus.start && (state_q == S_IDLE) && !bus.flush) ||
                         ((state_q != S_IDLE) && (state_q != S_DONE));
    assign bus.done    = (state_q == S_DONE);
    assign bus.result  = result_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed plus random self-checking bench for muldiv_sequencer with a result/latency scoreboard.
module tb_muldiv_sequencer;
    localparam int W = 32;
    localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;
    localparam int LAT_LONG = W + 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] dbg_state;

    muldiv_sequencer_if #(.DATA_WIDTH(W)) bus ();

    muldiv_sequencer #(.DATA_WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           passes = 0;
    logic [W-1:0] exp_q[$];
    int           lat_q[$];
    logic [W-1:0] last_result = '0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model built from the architectural definition of each RV32M op.
    function automatic logic [W-1:0] model(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [63:0] sa, sb, ub, p;
        logic        [63:0] up;
        logic signed [31:0] qa, qb, r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ub = {32'b0, b};
        qa = a;
        qb = b;
        case (f3)
            3'b000: begin p = sa * sb; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            3'b100: begin
                if (b == '0) return '1;
                if (a == MIN_NEG && b == '1) return MIN_NEG;
                r = qa / qb; return r;
            end
            3'b101: return (b == '0) ? '1 : a / b;
            3'b110: begin
                if (b == '0) return a;
                if (a == MIN_NEG && b == '1) return '0;
                r = qa % qb; return r;
            end
            default: return (b == '0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
        if (f3[2] && (b == '0)) return 2;
        if (f3[2] && !f3[0] && a == MIN_NEG && b == '1) return 2;
`ifdef MULDIV_ZERO_SKIP_EN
        if (f3[2] && a == '0) return 2;
        if (!f3[2] && (a == '0 || b == '0)) return 2;
`endif
        return LAT_LONG;
    endfunction

    // Moves into a fresh cycle, presents the request and checks the idle-start stall.
    task automatic launch(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        @(posedge clk);
        #1;
        check("idle_before_start", {31'b0, bus.busy}, '0);
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
        if (push) begin
            exp_q.push_back(model(f3, a, b));
            lat_q.push_back(model_lat(f3, a, b));
        end
        #1;
        check("stall_cycle0", {31'b0, bus.stall}, 32'd1);
    endtask

    task automatic wait_done(input string tag, input bit poke);
        int           n = 0;
        int           stall_cycles = 1;
        int           lat;
        logic [W-1:0] exp;
        while (n < 80) begin
            @(posedge clk);
            #1;
            n++;
            bus.start = 1'b0;
            if (poke && n == 5) begin
                bus.start  = 1'b1;
                bus.funct3 = 3'($urandom_range(0, 7));
                bus.op_a   = $urandom;
                bus.op_b   = $urandom;
            end
            if (bus.done) break;
            if (bus.stall) stall_cycles++;
        end
        bus.start = 1'b0;
        exp = exp_q.pop_front();
        lat = lat_q.pop_front();
        check({tag, "_latency"}, W'(n), W'(lat));
        check({tag, "_result"}, bus.result, exp);
        check({tag, "_stall_at_done"}, {31'b0, bus.stall}, '0);
        check({tag, "_stall_cycles"}, W'(stall_cycles), W'(lat));
        last_result = exp;
    endtask

    initial begin
        bit saw_done;
        logic [2:0] rf3;
        logic [W-1:0] ra, rb;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = '0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'b0, bus.busy}, '0);
        check("reset_done", {31'b0, bus.done}, '0);
        check("reset_stall", {31'b0, bus.stall}, '0);
        check("reset_result", bus.result, '0);
        check("reset_state", {29'b0, dbg_state}, '0);
        @(negedge clk);
        reset = 1'b0;

        launch(3'b000, 32'd7, 32'hFFFF_FFFD, 1); wait_done("mul", 0);
        launch(3'b011, '1, '1, 1);               wait_done("mulhu", 0);
        launch(3'b001, '1, '1, 1);               wait_done("mulh", 0);
        launch(3'b010, 32'hFFFF_FFFE, 32'h8000_0001, 1); wait_done("mulhsu", 0);
        launch(3'b100, 32'hFFFF_FFF9, 32'd2, 1); wait_done("div", 0);
        launch(3'b110, 32'hFFFF_FFF9, 32'd2, 1); wait_done("rem", 0);
        launch(3'b101, 32'd100, 32'd7, 1);       wait_done("divu_poke", 1);
        launch(3'b111, 32'd100, 32'd7, 1);       wait_done("remu", 0);
        launch(3'b101, 32'h1234_5678, '0, 1);    wait_done("divu_by0", 0);
        launch(3'b111, 32'h1234_5678, '0, 1);    wait_done("remu_by0", 0);
        launch(3'b100, MIN_NEG, '1, 1);          wait_done("div_ovf", 0);
        launch(3'b110, MIN_NEG, '1, 1);          wait_done("rem_ovf", 0);

        // start together with flush in IDLE must not be accepted
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush_blocks_start", {31'b0, bus.busy}, '0);

        // flush mid-divide at cycle 10, then a fresh multiply
        launch(3'b100, 32'd1000, 32'd3, 0);
        saw_done = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.done) saw_done = 1'b1;
        end
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        if (bus.done) saw_done = 1'b1;
        check("flush_busy", {31'b0, bus.busy}, '0);
        check("flush_no_done", {31'b0, saw_done}, '0);
        check("flush_result_held", bus.result, last_result);
        launch(3'b000, 32'd3, 32'd5, 1); wait_done("mul_after_flush", 0);

        // asynchronous reset in the middle of an operation
        launch(3'b011, 32'hDEAD_BEEF, 32'h1234_5678, 0);
        repeat (20) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_busy", {31'b0, bus.busy}, '0);
        check("async_rst_done", {31'b0, bus.done}, '0);
        check("async_rst_result", bus.result, '0);
        @(negedge clk);
        reset = 1'b0;
        launch(3'b111, 32'd100, 32'd7, 1); wait_done("remu_after_rst", 0);

        for (int i = 0; i < 8; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = (i % 2 == 0) ? $urandom : 32'($urandom_range(0, 1000));
            rb  = (i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
            launch(rf3, ra, rb, 1);
            wait_done("random", 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
